decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_seq.sv | 171 +++++++++++++++++
 tb/tb_decoder_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// decoder_seq -- sequenced one-cold decoder.
//   An accepted request drives y_n[addr] low for HOLD cycles. The selects then
//   sit all-high for GAP cycles before the next request can be taken.
//   Optional scan feature: macro DECODER_SEQ_SCAN_EN (disabled by default).
//   When enabled, the decoder walks every address in order.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/addr  decode request, accepted when req_ready is high
//   req_ready       high only in IDLE
//   y_n             registered, active-low, one-cold selects (2**AW bits)
//   busy            high whenever the state is not IDLE
//   done            one-cycle pulse on the last cycle of each HOLD window
//   scan_start      (scan build) starts a full-address scan from IDLE
//   scan_done       (scan build) pulses with the done of the last address
module decoder_seq #(
  parameter int AW   = 3,
  parameter int HOLD = 2,
  parameter int GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [AW-1:0]        req_addr,
  output logic                 req_ready,
  output logic [(1<<AW)-1:0]   y_n,
  output logic                 busy,
  output logic                 done
`ifdef DECODER_SEQ_SCAN_EN
  ,
  input  logic                 scan_start,
  output logic                 scan_done
`endif
);
  localparam int           N         = 1 << AW;
  localparam logic [N-1:0] ONE       = N'(1);
  localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);
  localparam logic [7:0]   GAP_LAST  = 8'(GAP - 1);  // only used when GAP > 0

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP
`ifdef DECODER_SEQ_SCAN_EN
    , S_SCAN_ACTIVE,
    S_SCAN_GAP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  y_d;
  logic [AW-1:0] addr_nx;
  logic          last_addr;

  function automatic logic [N-1:0] sel_n(input logic [AW-1:0] a);
    sel_n = ~(ONE << a);
  endfunction

  assign addr_nx   = addr_q + 1'b1;
  assign last_addr = (addr_q == '1);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      y_n     <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      y_n     <= y_d;
    end
  end

  // The next value of y_n is computed alongside the next state. This keeps the
  // selects flop-driven and lets them change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    y_d     = y_n;
    done    = 1'b0;
`ifdef DECODER_SEQ_SCAN_EN
    scan_done = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef DECODER_SEQ_SCAN_EN
        // scan_start has priority; a concurrent request stays pending
        if (scan_start) begin
          state_d = S_SCAN_ACTIVE;
          addr_d  = '0;
          cnt_d   = '0;
          y_d     = sel_n('0);
        end else
`endif
        if (req_valid) begin
          state_d = S_ACTIVE;
          addr_d  = req_addr;
          cnt_d   = '0;
          y_d     = sel_n(req_addr);
        end
      end
      S_ACTIVE: begin
        if (cnt_q == HOLD_LAST) begin
          done  = 1'b1;
          cnt_d = '0;
          y_d   = '1;
          if (GAP > 0) state_d = S_GAP;
          else         state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef DECODER_SEQ_SCAN_EN
      S_SCAN_ACTIVE: begin
        if (cnt_q == HOLD_LAST) begin
          done      = 1'b1;
          scan_done = last_addr;
          cnt_d     = '0;
          if (GAP > 0) begin
            state_d = S_SCAN_GAP;
            y_d     = '1;
          end else if (last_addr) begin
            state_d = S_IDLE;
            y_d     = '1;
          end else begin
            // no gap: hand the select straight to the next address
            addr_d = addr_nx;
            y_d    = sel_n(addr_nx);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SCAN_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          // the scan ends in IDLE; it does not wrap back to address 0
          if (last_addr) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SCAN_ACTIVE;
            addr_d  = addr_nx;
            y_d     = sel_n(addr_nx);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        y_d     = '1;
      end
    endcase
  end
endmodule

// File: tb/tb_decoder_seq.sv
module tb_decoder_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, v2;
  logic [2:0] a1, a2;
  logic       rdy1, rdy2, busy1, busy2, done1, done2;
  logic [7:0] y1, y2;
  int         checks = 0;
  int         errors = 0;
`ifdef DECODER_SEQ_SCAN_EN
  logic       ss1;
  logic       sd1, sd2;
`endif

  always #5 clk = ~clk;

  decoder_seq #(.AW(3), .HOLD(2), .GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_addr(a1),
    .req_ready(rdy1), .y_n(y1), .busy(busy1), .done(done1)
`ifdef DECODER_SEQ_SCAN_EN
    , .scan_start(ss1), .scan_done(sd1)
`endif
  );

  decoder_seq #(.AW(3), .HOLD(1), .GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_addr(a2),
    .req_ready(rdy2), .y_n(y2), .busy(busy2), .done(done2)
`ifdef DECODER_SEQ_SCAN_EN
    , .scan_start(1'b0), .scan_done(sd2)
`endif
  );

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] y;
    logic       rdy;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one select may be low in any cycle, on either instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onecold_dut1", 32'(($countones(~y1) <= 1)), 32'd1);
      chk("onecold_dut2", 32'(($countones(~y2) <= 1)), 32'd1);
    end
  end

  initial begin
    // single request at addr 5, then a request held with addr 0 -> 6 -> 7
    vecs[0]  = '{1'b1, 3'd5, 8'hDF, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd5, 8'hDF, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 3'd5, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'd6, 8'hFE, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 3'd7, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd7, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'd2, 8'h7F, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 3'd2, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'd2, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; v1 = 1'b0; a1 = '0; v2 = 1'b0; a2 = '0;
`ifdef DECODER_SEQ_SCAN_EN
    ss1 = 1'b0;
`endif
    #12;
    chk("reset_hold", {y1, rdy1, busy1, done1}, {8'hFF, 3'b100});
    rst_n = 1'b1;
    tick();
    chk("reset_release", {y1, rdy1, busy1, done1}, {8'hFF, 3'b100});

    for (int i = 0; i < 12; i++) begin
      v1 = vecs[i].v;
      a1 = vecs[i].a;
      tick();
      chk($sformatf("vec%0d", i), {y1, rdy1, busy1, done1},
          {vecs[i].y, vecs[i].rdy, vecs[i].busy, vecs[i].done});
    end

    // reset pulled low in the first ACTIVE cycle of addr 3
    v1 = 1'b1; a1 = 3'd3;
    tick();
    chk("mid_active", y1, 8'hF7);
    v1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {y1, rdy1, busy1, done1}, {8'hFF, 3'b100});
    tick();
    chk("reset_no_done", {y1, done1}, {8'hFF, 1'b0});
    #3 rst_n = 1'b1; v1 = 1'b1; a1 = 3'd1;
    tick();
    chk("first_edge_accept", {y1, rdy1, busy1}, {8'hFD, 2'b01});
    v1 = 1'b0;
    tick();
    chk("post_reset_done", {y1, done1}, {8'hFD, 1'b1});
    tick();
    tick();
    chk("post_reset_idle", {y1, rdy1, busy1}, {8'hFF, 2'b10});

    // GAP=0, HOLD=1: back-to-back addr 1 then addr 2
    v2 = 1'b1; a2 = 3'd1;
    tick();
    chk("g0_sel1", {y2, rdy2, busy2, done2}, {8'hFD, 3'b011});
    a2 = 3'd2;
    tick();
    chk("g0_idle", {y2, rdy2, busy2, done2}, {8'hFF, 3'b100});
    tick();
    chk("g0_sel2", {y2, rdy2, busy2, done2}, {8'hFB, 3'b011});
    v2 = 1'b0;
    tick();
    chk("g0_end", {y2, rdy2, busy2}, {8'hFF, 2'b10});

`ifdef DECODER_SEQ_SCAN_EN
    // scan wins over a concurrent request; the request is served afterwards
    ss1 = 1'b1; v1 = 1'b1; a1 = 3'd4;
    tick();
    ss1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] s;
      s = ~(8'd1 << i);
      chk($sformatf("scan%0d_c1", i), {y1, rdy1, busy1, done1, sd1}, {s, 4'b0100});
      tick();
      chk($sformatf("scan%0d_c2", i), {y1, rdy1, done1, sd1}, {s, 1'b0, 1'b1, 1'(i == 7)});
      tick();
      chk($sformatf("scan%0d_gap", i), {y1, rdy1, busy1, done1}, {8'hFF, 3'b010});
      tick();
    end
    chk("scan_idle", {y1, rdy1, busy1}, {8'hFF, 2'b10});
    tick();
    chk("scan_pending_req", {y1, rdy1}, {8'hEF, 1'b0});
    v1 = 1'b0;
    tick();
    tick();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
